pwm_multichannel_gen: RTL
=========================

// Module: pwm_multichannel_gen
// PURPOSE
//   Parametrised N-channel PWM generator. Replaces derived-clock, binary-weighted PWM with a single-clock design.
//   Shared prescaler and period counter; per-channel duty registers, double-buffered via a valid/ready config port.
//   Duty updates commit only at period boundaries, so no glitches. Sits between the ui_in/uio config logic and uo_out pads.
// PARAMETERS
//   WIDTH       8   bit width of period counter, period and duty values
//   CHANNELS    4   number of PWM outputs (1..8)
//   PRESCALE_W  8   bit width of prescaler and prescale value
// PORTS
//   clk             in   1                  sole clock; all state on posedge clk
//   rst_n           in   1                  asynchronous, active-low reset
//   ena             in   1                  block enable; low = idle, outputs forced 0
//   cfg_valid       in   1                  duty write request
//   cfg_ready       out  1                  duty write can be accepted
//   cfg_ch          in   $clog2(CHANNELS)   target channel of write
//   cfg_duty        in   WIDTH              duty value: high count per period
//   period_i        in   WIDTH              period minus 1, level input
//   prescale_i      in   PRESCALE_W         ticks every prescale_i+1 clocks, level input
//   pwm_o           out  CHANNELS           registered PWM outputs
//   period_start_o  out  1                  one-cycle pulse on first cycle of each period
// BEHAVIOUR
//   - Reset (rst_n=0, async): prescaler=0, cnt=0, period_act='1, prescale_act=0, duty_act[*]=0, duty_pend[*]=0,
//     pwm_o=0, period_start_o=0. cfg_ready=0 during reset.
//   - Prescaler: counts 0..prescale_act; tick=1 when it equals prescale_act, then wraps to 0. prescale_act=0 -> tick every clk.
//   - Period counter (edge-aligned): on tick, cnt = (cnt==period_act) ? 0 : cnt+1.
//     Boundary: tick && cnt==period_act.
//   - At boundary: duty_act[*]<=duty_pend[*]; period_act<=period_i; prescale_act<=prescale_i.
//   - Handshake: a write is accepted when cfg_valid && cfg_ready, setting duty_pend[cfg_ch]<=cfg_duty.
//     cfg_ready=0 in the boundary cycle; cfg_ready=1 otherwise (after reset).
//     A held cfg_valid is accepted the next cycle. cfg_ch>=CHANNELS: accepted, dropped.
//   - Same-channel writes before a boundary: last write wins.
//   - Output: pwm_o[c] <= ena && (cnt < duty_act[c]). Latency is 1 clk from cnt.
//     duty=0 -> constant 0. duty>period_act -> constant 1 (100%). Compare is WIDTH-bit unsigned, no overflow.
//   - period_start_o <= boundary, aligned with pwm_o's first cycle of the new period.
//   - period_act=0: every tick is a boundary. Output is 1 iff duty_act>0.
//   - ena=0: prescaler and cnt held at 0. Pending values commit every clk (duty, period, prescale).
//     cfg_ready=1. pwm_o=0 and period_start_o=0 next clk.
//     On ena rising, the first period starts at cnt=0 with the committed values.
//   - Reset mid-period: all state clears immediately; no partial pulse after release.
// CONFIGURATION
//   PWM_CENTER_ALIGN_EN defined:
//     - cnt counts up 0..period_act, then down to 0 (triangle). Full period = 2*period_act ticks.
//     - pwm_o[c] = cnt < duty_act[c], giving pulses symmetric about the cnt=0 turnaround.
//     - Boundary is the tick where cnt==0 while counting down, or period_act==0.
//     - Up/down direction flop resets to "up".
//   PWM_CENTER_ALIGN_EN undefined: edge-aligned up-counter only; no direction flop is synthesised.
// TESTING
//   1. Reset: rst_n=0 async mid-clock -> pwm_o=0, period_start_o=0, cfg_ready=0 immediately; after release, cfg_ready=1 next clk.
//   2. Basic duty: prescale=0, period=9, ch0 duty=3 -> pwm_o[0] high 3 clks of every 10; period_start_o pulses every 10 clks.
//   3. Extremes: ch1 duty=0 -> constant 0. ch2 duty=10 with period=9 -> constant 1. ch3 duty=255 -> constant 1.
//   4. Glitch-free update: ch0 duty 3->7 written mid-period -> current period still 3 high, next period 7 high.
//      Write coinciding with boundary -> cfg_ready=0 that clk, accepted next clk, applied one period later.
//   5. Prescale: prescale=3, period=4, duty=2 -> high 8 clks of every 20; changing prescale mid-period takes effect at boundary.
//   6. ena low for 5 clks mid-period -> pwm_o=0; on re-enable, cnt restarts at 0 and period_start_o pulses at first boundary.
//      With PWM_CENTER_ALIGN_EN, period=4, duty=2 -> 8-tick period, high centred.

Source files
------------

// File: rtl/pwm_multichannel_gen_if.sv
// Duty-cycle configuration port for pwm_multichannel_gen.
//   cfg_valid : write request from the config logic
//   cfg_ready : write can be accepted this cycle
//   cfg_ch    : target channel of the write
//   cfg_duty  : duty value (high count per period)
// master = config source, slave = PWM generator.
interface pwm_multichannel_gen_if #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 4
);
   localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [WIDTH-1:0] cfg_duty;

   modport master (output cfg_valid, output cfg_ch, output cfg_duty, input cfg_ready);
   modport slave  (input cfg_valid, input cfg_ch, input cfg_duty, output cfg_ready);
endinterface

// File: rtl/pwm_multichannel_gen.sv
// N-channel single-clock PWM generator with a shared prescaler and period
// counter. Duty values are double-buffered: writes land in a pending bank and
// are committed to the active bank only at period boundaries (or continuously
// while disabled), so outputs never glitch mid-period.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   ena            : block enable; low holds counters at 0 and forces outputs low
//   cfg            : duty write port (valid/ready, channel, duty)
//   period_i       : period minus 1 (sampled at boundaries)
//   prescale_i     : tick every prescale_i+1 clocks (sampled at boundaries)
//   pwm_o          : registered PWM outputs
//   period_start_o : one-cycle pulse aligned with the first pwm_o cycle of a period
// Build option: define PWM_CENTER_ALIGN_EN for an up/down (centre-aligned) counter.
module pwm_multichannel_gen #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned CHANNELS   = 4,
   parameter int unsigned PRESCALE_W = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ena,
   pwm_multichannel_gen_if.slave   cfg,
   input  logic [WIDTH-1:0]        period_i,
   input  logic [PRESCALE_W-1:0]   prescale_i,
   output logic [CHANNELS-1:0]     pwm_o,
   output logic                    period_start_o
);
   localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [PRESCALE_W-1:0] presc_q, presc_d, prescale_act;
   logic [WIDTH-1:0]      cnt_q, cnt_d, period_act;
   logic [WIDTH-1:0]      duty_act  [CHANNELS];
   logic [WIDTH-1:0]      duty_pend [CHANNELS];
   logic                  rdy_q;
   logic                  boundary_q;
   logic                  tick, boundary, commit, wr_en;
`ifdef PWM_CENTER_ALIGN_EN
   logic                  dir_q, dir_d;   // 0 = counting up, 1 = counting down
`endif

   assign tick = (presc_q == prescale_act);

`ifdef PWM_CENTER_ALIGN_EN
   assign boundary = ena && tick && ((dir_q && (cnt_q == '0)) || (period_act == '0));
`else
   assign boundary = ena && tick && (cnt_q == period_act);
`endif

   // Disabled: the active bank tracks the pending bank every clock.
   assign commit        = boundary || !ena;
   assign cfg.cfg_ready = rdy_q && !boundary;
   assign wr_en         = cfg.cfg_valid && cfg.cfg_ready;

   // Next prescaler / period counter state.
   always_comb begin
      presc_d = presc_q + PRESCALE_W'(1);
      cnt_d   = cnt_q;
`ifdef PWM_CENTER_ALIGN_EN
      dir_d   = dir_q;
`endif
      if (!ena) begin
         presc_d = '0;
         cnt_d   = '0;
`ifdef PWM_CENTER_ALIGN_EN
         dir_d   = 1'b0;
`endif
      end else if (tick) begin
         presc_d = '0;
`ifdef PWM_CENTER_ALIGN_EN
         if (period_act == '0) begin
            cnt_d = '0;
            dir_d = 1'b0;
         end else if (!dir_q) begin
            if (cnt_q == period_act) begin
               cnt_d = cnt_q - WIDTH'(1);
               dir_d = 1'b1;
            end else begin
               cnt_d = cnt_q + WIDTH'(1);
            end
         end else if (cnt_q == '0) begin
            // Turnaround at the boundary; the new period starts already climbing.
            cnt_d = (period_i == '0) ? '0 : WIDTH'(1);
            dir_d = 1'b0;
         end else begin
            cnt_d = cnt_q - WIDTH'(1);
         end
`else
         cnt_d = (cnt_q == period_act) ? '0 : cnt_q + WIDTH'(1);
`endif
      end
   end

   // State, double-buffered configuration and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q        <= '0;
         cnt_q          <= '0;
         period_act     <= '1;
         prescale_act   <= '0;
         rdy_q          <= 1'b0;
         boundary_q     <= 1'b0;
         pwm_o          <= '0;
         period_start_o <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
         dir_q          <= 1'b0;
`endif
         for (int c = 0; c < CHANNELS; c++) begin
            duty_act[c]  <= '0;
            duty_pend[c] <= '0;
         end
      end else begin
         presc_q    <= presc_d;
         cnt_q      <= cnt_d;
         rdy_q      <= 1'b1;
`ifdef PWM_CENTER_ALIGN_EN
         dir_q      <= dir_d;
`endif
         // boundary_q delays the pulse so it lines up with pwm_o's 1-clk latency.
         boundary_q     <= boundary;
         period_start_o <= ena && boundary_q;
         if (commit) begin
            period_act   <= period_i;
            prescale_act <= prescale_i;
         end
         for (int c = 0; c < CHANNELS; c++) begin
            if (commit) duty_act[c] <= duty_pend[c];
            // Out-of-range channel numbers match no entry and are dropped.
            if (wr_en && (cfg.cfg_ch == CH_W'(c))) duty_pend[c] <= cfg.cfg_duty;
            pwm_o[c] <= ena && (cnt_q < duty_act[c]);
         end
      end
   end
endmodule
